// File: rtl/addr_adder_arb_pkg.sv
// Shared types and constants for the address-adder arbiter.
package addr_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    localparam int REQ_FETCH  = 0;
    localparam int REQ_BRANCH = 1;
    localparam int REQ_LSU    = 2;

    // Increment with wrap at n, used for the round-robin pointer.
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/addr_adder_arb_if.sv
// Request/response bundle between the requesters (master) and the shared adder (slave).
interface addr_adder_arb_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 3,
    parameter int IDW   = 2
);
    logic                    flush;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*WIDTH-1:0]   req_a;
    logic [NREQ*WIDTH-1:0]   req_b;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ-1:0]         rsp_valid;
    logic [WIDTH-1:0]        rsp_data;
    logic [IDW-1:0]          rsp_id;
    logic [NREQ-1:0]         rsp_ready;

    modport master (
        output flush, req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  flush, req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/addr_adder_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
// Zero latency; no state, no backpressure of its own.
module rr_pick #(
    parameter int NREQ = 3,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_idx
);

    function automatic int slot(input int k);
        return (int'(i_ptr) + k) % NREQ;
    endfunction

    // Scan from the farthest slot back to the pointer so the nearest hit wins.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (i_req[slot(k)]) begin
                o_gnt          = '0;
                o_gnt[slot(k)] = 1'b1;
                o_idx          = IDW'(slot(k));
            end
        end
    end

endmodule

// File: rtl/addr_adder_arb.sv
// Shares one WIDTH-bit adder among NREQ requesters, round-robin; ADDR_ARB_FETCH_PRIO_EN gives requester 0 fixed priority.
// Latency: sum registered, valid the cycle after the grant; one sum per cycle sustained.
// Backpressure: a held response blocks new grants until its owner asserts rsp_ready; flush drops it.
module addr_adder_arb
    import addr_arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 3,
    parameter int IDW   = 2
) (
    input  logic              clk,
    input  logic              rst,
    addr_adder_arb_if.slave   bus
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_rsp_data;
    logic [IDW-1:0]   r_rsp_id;
    logic [IDW-1:0]   r_rr_ptr;

    logic [NREQ-1:0]  w_rr_req;
    logic [NREQ-1:0]  w_rr_gnt;
    logic [IDW-1:0]   w_rr_idx;
    logic [NREQ-1:0]  w_gnt_oh;
    logic [IDW-1:0]   w_gnt_idx;
    logic [NREQ-1:0]  w_rsp_vld;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_op_b;
    logic [WIDTH-1:0] w_sum;
    logic             w_own_rdy;
    logic             w_can_accept;
    logic             w_grant;
    logic             w_adv_ptr;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .i_req (w_rr_req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_rr_gnt),
        .o_idx (w_rr_idx)
    );

`ifdef ADDR_ARB_FETCH_PRIO_EN
    localparam logic [NREQ-1:0] FETCH_MASK = NREQ'(1) << REQ_FETCH;

    // Fetch bypasses the rotation entirely, so its grants leave rr_ptr alone.
    assign w_rr_req  = bus.req_valid & ~FETCH_MASK;
    assign w_gnt_oh  = bus.req_valid[REQ_FETCH] ? FETCH_MASK : w_rr_gnt;
    assign w_gnt_idx = bus.req_valid[REQ_FETCH] ? IDW'(REQ_FETCH) : w_rr_idx;
    assign w_adv_ptr = w_grant && !bus.req_valid[REQ_FETCH];
`else
    assign w_rr_req  = bus.req_valid;
    assign w_gnt_oh  = w_rr_gnt;
    assign w_gnt_idx = w_rr_idx;
    assign w_adv_ptr = w_grant;
`endif

    always_comb begin
        w_rsp_vld = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_rsp_vld[i] = (r_state == ST_RESP) && (r_rsp_id == IDW'(i));
        end
    end

    // Only the owner's rsp_ready matters; the others are masked by w_rsp_vld.
    assign w_own_rdy    = |(w_rsp_vld & bus.rsp_ready);
    assign w_can_accept = (r_state == ST_IDLE) || w_own_rdy;
    assign w_grant      = !rst && w_can_accept && !bus.flush && (|bus.req_valid);

    // Select operands first so a single adder serves every requester.
    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_oh[i]) begin
                w_op_a = w_op_a | bus.req_a[i*WIDTH +: WIDTH];
                w_op_b = w_op_b | bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_sum = w_op_a + w_op_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.flush) begin
            w_state_nxt = ST_IDLE;
        end else if (w_grant) begin
            w_state_nxt = ST_RESP;
        end else if (w_own_rdy) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_data <= '0;
            r_rsp_id   <= '0;
            r_rr_ptr   <= '0;
        end else begin
            if (w_grant) begin
                r_rsp_data <= w_sum;
                r_rsp_id   <= w_gnt_idx;
            end
            if (w_adv_ptr) begin
                r_rr_ptr <= IDW'(wrap_inc(int'(w_gnt_idx), NREQ));
            end
        end
    end

    assign bus.req_ready = w_grant ? w_gnt_oh : '0;
    assign bus.rsp_valid = w_rsp_vld;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_addr_adder_arb.sv
// Directed, table-driven bench for addr_adder_arb plus an asynchronous mid-response reset sequence.
module tb_addr_adder_arb;
    import addr_arb_pkg::*;

    localparam int WIDTH = 32;
    localparam int NREQ  = 3;
    localparam int IDW   = 2;

    localparam logic [31:0] A0 = 32'h0000_1000, B0 = 32'h0000_0004, S0 = 32'h0000_1004;
    localparam logic [31:0] A1 = 32'h0000_2000, B1 = 32'h0000_0010, S1 = 32'h0000_2010;
    localparam logic [31:0] A2 = 32'hFFFF_FFFC, B2 = 32'h0000_0008, S2 = 32'h0000_0004;

    localparam logic [1:0] ID0 = 2'(REQ_FETCH);
    localparam logic [1:0] ID1 = 2'(REQ_BRANCH);
    localparam logic [1:0] ID2 = 2'(REQ_LSU);

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    addr_adder_arb_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();

    addr_adder_arb #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic [2:0]  rv;
        logic [2:0]  rr;
        logic [2:0]  e_rq;
        logic [2:0]  e_rv;
        logic [1:0]  e_id;
        logic [31:0] e_data;
        logic        chk;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic fl, input logic [2:0] rv, input logic [2:0] rr,
                       input logic [2:0] e_rq, input logic [2:0] e_rv,
                       input logic [1:0] e_id, input logic [31:0] e_data, input logic chk);
        vec_t v;
        v.flush = fl; v.rv = rv; v.rr = rr; v.e_rq = e_rq; v.e_rv = e_rv;
        v.e_id = e_id; v.e_data = e_data; v.chk = chk;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int row, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h, expected %h", name, row, got, exp);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        bus.req_a     = {A2, A1, A0};
        bus.req_b     = {B2, B1, B0};

        // Reset state, including req_ready held low with requests present.
        @(negedge clk);
        bus.req_valid = 3'b111;
        #1;
        check("rst_req_ready", -1, 32'(bus.req_ready), 32'h0);
        check("rst_rsp_valid", -1, 32'(bus.rsp_valid), 32'h0);
        check("rst_rsp_data",  -1, bus.rsp_data,        32'h0);
        check("rst_rsp_id",    -1, 32'(bus.rsp_id),     32'h0);
        @(negedge clk);
        bus.req_valid = '0;
        rst           = 1'b0;

`ifndef ADDR_ARB_FETCH_PRIO_EN
        //   fl  rv      rr      req_rdy rsp_vld id   data chk
        add(0, 3'b000, 3'b000, 3'b000, 3'b000, ID0, 32'h0, 1);
        add(0, 3'b001, 3'b000, 3'b001, 3'b000, ID0, 32'h0, 0);
        add(0, 3'b000, 3'b001, 3'b000, 3'b001, ID0, S0,    1);
        add(0, 3'b111, 3'b111, 3'b010, 3'b000, ID0, S0,    0);
        add(0, 3'b111, 3'b111, 3'b100, 3'b010, ID1, S1,    1);
        add(0, 3'b111, 3'b111, 3'b001, 3'b100, ID2, S2,    1);
        add(0, 3'b111, 3'b111, 3'b010, 3'b001, ID0, S0,    1);
        add(0, 3'b111, 3'b000, 3'b000, 3'b010, ID1, S1,    1);
        add(0, 3'b111, 3'b101, 3'b000, 3'b010, ID1, S1,    1);
        add(0, 3'b111, 3'b000, 3'b000, 3'b010, ID1, S1,    1);
        add(0, 3'b111, 3'b010, 3'b100, 3'b010, ID1, S1,    1);
        add(1, 3'b010, 3'b100, 3'b000, 3'b100, ID2, S2,    1);
        add(0, 3'b010, 3'b000, 3'b010, 3'b000, ID0, S0,    0);
        add(0, 3'b001, 3'b000, 3'b000, 3'b010, ID1, S1,    1);
        add(0, 3'b001, 3'b010, 3'b001, 3'b010, ID1, S1,    1);
        add(0, 3'b000, 3'b000, 3'b000, 3'b001, ID0, S0,    1);
        add(0, 3'b000, 3'b001, 3'b000, 3'b001, ID0, S0,    1);
        add(0, 3'b000, 3'b000, 3'b000, 3'b000, ID0, S0,    0);
        add(0, 3'b101, 3'b000, 3'b100, 3'b000, ID0, S0,    0);
        add(0, 3'b000, 3'b100, 3'b000, 3'b100, ID2, S2,    1);
        add(0, 3'b000, 3'b000, 3'b000, 3'b000, ID0, S0,    0);
        add(1, 3'b011, 3'b000, 3'b000, 3'b000, ID0, S0,    0);
        add(0, 3'b011, 3'b000, 3'b001, 3'b000, ID0, S0,    0);
        add(0, 3'b000, 3'b001, 3'b000, 3'b001, ID0, S0,    1);
`else
        add(0, 3'b000, 3'b000, 3'b000, 3'b000, ID0, 32'h0, 1);
        add(0, 3'b111, 3'b111, 3'b001, 3'b000, ID0, 32'h0, 0);
        add(0, 3'b111, 3'b111, 3'b001, 3'b001, ID0, S0,    1);
        add(0, 3'b111, 3'b111, 3'b001, 3'b001, ID0, S0,    1);
        add(0, 3'b110, 3'b111, 3'b010, 3'b001, ID0, S0,    1);
        add(0, 3'b110, 3'b111, 3'b100, 3'b010, ID1, S1,    1);
        add(0, 3'b110, 3'b111, 3'b010, 3'b100, ID2, S2,    1);
        add(0, 3'b111, 3'b111, 3'b001, 3'b010, ID1, S1,    1);
        add(0, 3'b110, 3'b111, 3'b100, 3'b001, ID0, S0,    1);
        add(0, 3'b000, 3'b100, 3'b000, 3'b100, ID2, S2,    1);
        add(0, 3'b000, 3'b000, 3'b000, 3'b000, ID0, S0,    0);
`endif

        foreach (vecs[i]) begin
            @(negedge clk);
            bus.flush     = vecs[i].flush;
            bus.req_valid = vecs[i].rv;
            bus.rsp_ready = vecs[i].rr;
            #1;
            check("req_ready", i, 32'(bus.req_ready), 32'(vecs[i].e_rq));
            check("rsp_valid", i, 32'(bus.rsp_valid), 32'(vecs[i].e_rv));
            if (vecs[i].chk) begin
                check("rsp_data", i, bus.rsp_data,    vecs[i].e_data);
                check("rsp_id",   i, 32'(bus.rsp_id), 32'(vecs[i].e_id));
            end
        end

        // Asynchronous reset while a response is held.
        @(negedge clk);
        bus.flush     = 1'b0;
        bus.req_valid = 3'b010;
        bus.rsp_ready = 3'b000;
        @(posedge clk);
        #2;
        bus.req_valid = 3'b000;
        #1;
        check("pre_rst_rsp_valid", 100, 32'(bus.rsp_valid), 32'(3'b010));
        check("pre_rst_rsp_data",  100, bus.rsp_data,        S1);
        bus.req_valid = 3'b001;
        rst           = 1'b1;
        #1;
        check("async_rst_rsp_valid", 101, 32'(bus.rsp_valid), 32'h0);
        check("async_rst_rsp_data",  101, bus.rsp_data,        32'h0);
        check("async_rst_rsp_id",    101, 32'(bus.rsp_id),     32'h0);
        check("async_rst_req_ready", 101, 32'(bus.req_ready),  32'h0);
        @(negedge clk);
        rst           = 1'b0;
        bus.req_valid = 3'b000;
        #1;
        check("post_rst_rsp_valid", 102, 32'(bus.rsp_valid), 32'h0);

        // Pointer restarts at 0 after reset: all valid grants requester 0.
        @(negedge clk);
        bus.req_valid = 3'b111;
        #1;
        check("post_rst_grant", 103, 32'(bus.req_ready), 32'(3'b001));
        @(negedge clk);
        bus.req_valid = 3'b000;
        bus.rsp_ready = 3'b001;
        #1;
        check("post_rst_data", 104, bus.rsp_data, S0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/addr_adder_arb.md
Name: addr_adder_arb

Overview:
- Shares one 32-bit address adder between up to NREQ requesters. Default requesters:
  - 0 = fetch PC+4
  - 1 = branch/jump target
  - 2 = load/store effective address
- Round-robin arbitration with a valid/ready handshake on both the request side and the response side.
- Result is registered: one-cycle latency, back-to-back throughput of one sum per cycle.
- Sits between the core's front-end/execute stages and the address adder, so the IGLOO2 build carries a single 32-bit adder instead of three.

Parameters:
- WIDTH, 32, operand/result width.
- NREQ, 3, number of requesters (2..8).
- IDW, 2, requester-id width; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  discards any held response and suppresses grants this cycle.
- req_valid  input  NREQ  per-requester request valid.
- req_a  input  NREQ*WIDTH  operand A, slice i = [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  operand B, same packing.
- req_ready  output  NREQ  one-hot grant/accept.
- rsp_valid  output  NREQ  one-hot response valid to the owning requester.
- rsp_data  output  WIDTH  registered sum.
- rsp_id  output  IDW  requester id of the held response.
- rsp_ready  input  NREQ  per-requester response accept.

Behaviour:
- Reset: clock and reset are a single clk with asynchronous, active-high rst. On reset: state=IDLE, rr_ptr=0, rsp_data=0, rsp_id=0, rsp_valid=0. req_ready is combinational and is 0 while rst=1.
- States:
  - IDLE: no response held.
  - RESP: response held in the output register.
- can_accept = (state==IDLE) | (state==RESP & rsp_ready[rsp_id]).
- Grant:
  - When can_accept & !flush & |req_valid, the grant g is the first set req_valid bit searching from rr_ptr upward, wrapping modulo NREQ.
  - req_ready[g]=1 in the same cycle (combinational). The handshake completes that cycle.
- Grant effects at the clock edge:
  - rsp_data <= a[g]+b[g], modulo 2**WIDTH; carry-out is discarded, so 0xFFFFFFFC+4 = 0x00000000.
  - rsp_id <= g; state <= RESP.
  - rr_ptr <= (g+1) mod NREQ.
- No grant:
  - RESP & rsp_ready[rsp_id] → IDLE.
  - Otherwise the state holds. rsp_data and rsp_id stay stable while rsp_valid is high.
- Response: rsp_valid[i] = (state==RESP) & (rsp_id==i). rsp_ready bits of non-owning requesters are ignored.
- Latency: request accepted in cycle N → response valid in cycle N+1. Consuming a response and accepting a new request in the same cycle is legal, giving 1 sum/cycle.
- Requester rules: req_valid must not drop, and operands must stay stable, until req_ready is seen. The arbiter does not check this.
- flush:
  - Forces state <= IDLE next cycle and drops the held response.
  - req_ready=0 that cycle.
  - rr_ptr is unchanged.
  - flush wins over a simultaneous rsp_ready or req_valid.
- rr_ptr advances only on a grant. Idle cycles do not rotate it.
- Single requester valid: it is granted every accept slot regardless of rr_ptr.
- Reset asserted mid-response: the response is lost and the registers take their reset values immediately (asynchronous).

Optional Feature:
- Macro ADDR_ARB_FETCH_PRIO_EN.
- Defined: requester 0 has fixed highest priority; whenever req_valid[0]=1 at an accept slot, it is granted. Requesters 1..NREQ-1 round-robin among themselves; rr_ptr ignores grants to 0.
- Undefined: pure round-robin over all NREQ, as above.

Decomposition:
- Shared package addr_arb_pkg:
  - state encoding localparams ST_IDLE=1'b0, ST_RESP=1'b1.
  - requester id constants REQ_FETCH=0, REQ_BRANCH=1, REQ_LSU=2.
- One sub-module, rr_pick: a combinational round-robin picker.
  - Inputs: NREQ-bit request vector, rr_ptr.
  - Outputs: one-hot grant and its binary index.
  - Instantiated once. The adder, operand mux and FSM stay in addr_adder_arb.

Test Plan:
- Single request, no flush: req_valid=001, a0=0x00001000, b0=4 → req_ready=001 same cycle; next cycle rsp_valid=001, rsp_data=0x00001004, rsp_id=0.
- Three requesters always valid, rsp_ready=111 → grants rotate 0,1,2,0,…, one per cycle. rsp_data alternates a_i+b_i per grant with no idle cycles.
- Backpressure: hold rsp_ready=0 for 3 cycles with requests pending:
  - rsp_data/rsp_id stay stable and req_ready=000.
  - Release → next grant issued in the same cycle.
- Wrap-around: a=0xFFFFFFFC, b=0x00000008 → rsp_data=0x00000004, no other side effect.
- Flush while state=RESP with req_valid=010 → no grant that cycle; next cycle rsp_valid=000, state IDLE, rr_ptr unchanged; grant to 1 the following cycle.
- With ADDR_ARB_FETCH_PRIO_EN: req_valid=111 held → requester 0 granted every cycle. Drop req_valid[0] → 1 and 2 alternate. Assert rst mid-RESP → rsp_valid=000 immediately.
